if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the PC, drives the combinational instruction ROM (ce/addr),
//  captures each returned 64-bit instruction with its PC into a small FIFO, and presents
//  {pc, inst} to the decode stage over a valid/ready handshake. Accepts pipeline stall and
//  branch/exception redirect from downstream control.
// PARAMETERS
//  ADDR_W    32   PC / ROM address width (byte address)
//  INST_W    64   instruction width; PC step is 8 bytes
//  RESET_PC  0    PC loaded on reset
//  DEPTH     2    fetch FIFO entries; power of two, >= 2
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-high reset
//  rom_ce_o       out  1       ROM chip enable; 1 = fetch this cycle
//  rom_addr_o     out  ADDR_W  ROM byte address = current PC
//  rom_inst_i     in   INST_W  ROM data, valid in the same cycle as rom_ce_o/rom_addr_o
//  stall_i        in   1       hold PC and issue no fetch
//  redirect_i     in   1       branch/exception taken; flush and reload PC
//  redirect_pc_i  in   ADDR_W  redirect target
//  id_valid_o     out  1       FIFO head valid
//  id_ready_i     in   1       decode accepts head this cycle
//  id_pc_o        out  ADDR_W  PC of head instruction
//  id_inst_o      out  INST_W  head instruction
// BEHAVIOUR
//  Reset (async, holds while rst=1):
//  - state=IDLE, pc=RESET_PC, FIFO empty.
//  - rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
//  FSM:
//  - IDLE -> FETCH on the first edge with rst=0. IDLE never fetches.
//  - FETCH is held until reset.
//  - rom_ce_o = (state==FETCH) & !stall_i & !redirect_i & (!full | pop).
//  - rom_addr_o = pc at all times.
//  pop:
//  - pop = id_valid_o & id_ready_i. Head advances on the next edge.
//  push:
//  - push = rom_ce_o. On the edge, enqueue {pc, rom_inst_i} and set pc <= pc + 8.
//  - Addition is modulo 2^ADDR_W: 0xFFFFFFF8 wraps to 0x0.
//  - push and pop in the same cycle are both allowed, including when full; count is unchanged.
//  - One instruction per cycle sustained when id_ready_i=1.
//  Latency:
//  - First rom_ce_o=1 occurs in the cycle after the first edge with rst=0.
//  - The matching id_valid_o=1 follows one edge later.
//  Stall:
//  - PC frozen, no push. Pop still proceeds, so the FIFO drains.
//  Redirect (priority over stall and push):
//  - On the edge: FIFO emptied, pc <= redirect_pc_i with bits [2:0] forced to 0.
//  - A pop in the same cycle is discarded with the flush.
//  - id_valid_o=0 in the following cycle. First fetch of the target occurs in that same cycle
//    if stall_i=0.
//  Outputs:
//  - id_pc_o and id_inst_o come straight from FIFO storage (no combinational path from
//    rom_inst_i).
//  - They hold their last value when empty, except after reset.
//  Counters:
//  - wr_ptr/rd_ptr are log2(DEPTH) bits and wrap naturally.
//  - count is log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
//  Reset mid-operation: immediate return to the reset values above; no partial entries survive.
// TESTING
//  1 Reset: assert rst for 3 cycles -> rom_ce_o=0, rom_addr_o=0, id_valid_o=0.
//    Release -> rom_ce_o=1 in cycle 2, id_valid_o=1 in cycle 3.
//  2 Stream, id_ready_i=1, ROM returns addr-tagged data -> id_pc_o = 0x0,0x8,0x10,...
//    on consecutive cycles; id_inst_o matches each address.
//  3 Backpressure, id_ready_i=0 from reset -> FIFO holds PCs 0x0,0x8; rom_ce_o=0, pc stuck at 0x10.
//    Raise ready -> 0x0,0x8,0x10 delivered in order, no gaps.
//  4 Redirect to 0x103 while FIFO full and stall_i=1 -> next cycle id_valid_o=0, rom_addr_o=0x100.
//    Drop stall -> PCs 0x100,0x108 delivered; no stale entries.
//  5 Wrap: RESET_PC=0xFFFFFFF8 -> PCs 0xFFFFFFF8 then 0x00000000.
//  6 Assert rst mid-stream with 2 entries queued -> outputs reset asynchronously;
//    after release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction ROM port, downstream control, and decode handoff.
// Pure wiring: no state, no latency of its own.
// Backpressure is carried by id_ready_i; stall/redirect arrive from pipeline control.
interface if_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
);
  // instruction ROM port
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [INST_W-1:0] rom_inst_i;

  // pipeline control
  logic              stall_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;

  // decode handoff
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;

  // the fetch unit side
  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_inst_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    output id_valid_o,
    input  id_ready_i,
    output id_pc_o,
    output id_inst_o
  );

  // the ROM / control / decode side
  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_inst_i,
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_pc_o,
    input  id_inst_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM, queues {pc, inst} for decode.
// Latency: first ROM read one cycle after reset release; queued entry visible one edge later.
// Backpressure: full FIFO stops fetching unless decode pops the same cycle; stall freezes PC.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master fb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              fetch_ok;
  logic [PTR_W-1:0]  head_idx;
  logic [ADDR_W-1:0] redirect_pc_aligned;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // fetching is allowed only when running and nothing from control blocks it
  assign fetch_ok = (state == ST_FETCH) && !fb.stall_i && !fb.redirect_i;

  assign pop  = fb.id_valid_o && fb.id_ready_i;
  assign push = fetch_ok && (!full || pop);

  assign redirect_pc_aligned = fb.redirect_pc_i & ALIGN_MASK;

  // when empty, show the slot just behind rd_ptr so the last delivered entry stays on the bus
  assign head_idx = empty ? (rd_ptr - PTR_ONE) : rd_ptr;

  assign fb.rom_ce_o   = push;
  assign fb.rom_addr_o = pc;
  assign fb.id_valid_o = !empty;
  assign fb.id_pc_o    = pc_mem[head_idx];
  assign fb.id_inst_o  = inst_mem[head_idx];

  // IDLE for exactly one edge after reset, then FETCH until the next reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (state == ST_IDLE) begin
      state <= ST_FETCH;
    end
  end

  // PC: redirect reloads an 8-byte-aligned target, otherwise step past each fetched word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (fb.redirect_i) begin
      pc <= redirect_pc_aligned;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // FIFO bookkeeping: flush on redirect, otherwise independent push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fb.redirect_i) begin
      // step past the head so the value on the bus stays put while empty
      count <= '0;
      if (!empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        wr_ptr <= rd_ptr + PTR_ONE;
      end else begin
        wr_ptr <= rd_ptr;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: cleared on reset so decode sees zeros, written with the ROM word on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= pc;
      inst_mem[wr_ptr] <= fb.rom_inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model checked every cycle plus directed literals.
// A second instance with RESET_PC=0xFFFFFFF8 covers PC wrap-around.
// Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  if_fetch_unit_if #(.ADDR_W(32), .INST_W(64)) bus ();
  if_fetch_unit_if #(.ADDR_W(32), .INST_W(64)) wbus ();

  if_fetch_unit #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .fb  (bus)
  );

  if_fetch_unit #(.ADDR_W(32), .INST_W(64), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk (clk),
    .rst (rst),
    .fb  (wbus)
  );

  // address-tagged ROM contents
  function automatic logic [63:0] rom_fn(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, a};
  endfunction

  assign bus.rom_inst_i  = rom_fn(bus.rom_addr_o);
  assign wbus.rom_inst_i = rom_fn(wbus.rom_addr_o);

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  bit          started;

  function automatic logic model_ce();
    return started && !bus.stall_i && !bus.redirect_i &&
           ((mq.size() < 2) || (mq.size() != 0 && bus.id_ready_i));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mpc     = 32'h0;
      started = 1'b0;
    end else begin
      if (bus.redirect_i) begin
        mq.delete();
        mpc = bus.redirect_pc_i & 32'hFFFF_FFF8;
      end else begin
        logic ce;
        ce = model_ce();
        if (mq.size() != 0 && bus.id_ready_i) void'(mq.pop_front());
        if (ce) begin
          mq.push_back('{pc: mpc, inst: rom_fn(mpc)});
          mpc = mpc + 32'd8;
        end
      end
      started = 1'b1;
    end
  end

  // every-cycle comparison of the main instance against the model
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ce",    {63'b0, bus.rom_ce_o},   64'h0);
      check("rst_addr",  {32'b0, bus.rom_addr_o}, 64'h0);
      check("rst_valid", {63'b0, bus.id_valid_o}, 64'h0);
      check("rst_pc",    {32'b0, bus.id_pc_o},    64'h0);
      check("rst_inst",  bus.id_inst_o,           64'h0);
    end else begin
      check("m_ce",    {63'b0, bus.rom_ce_o},   {63'b0, model_ce()});
      check("m_addr",  {32'b0, bus.rom_addr_o}, {32'b0, mpc});
      check("m_valid", {63'b0, bus.id_valid_o}, {63'b0, (mq.size() != 0)});
      if (mq.size() != 0) begin
        check("m_pc",   {32'b0, bus.id_pc_o}, {32'b0, mq[0].pc});
        check("m_inst", bus.id_inst_o,        mq[0].inst);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic go(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic lit_pc(input string nm, input logic [31:0] exp);
    check({nm, "_valid"}, {63'b0, bus.id_valid_o}, 64'h1);
    check({nm, "_pc"},    {32'b0, bus.id_pc_o},    {32'b0, exp});
    check({nm, "_inst"},  bus.id_inst_o,           rom_fn(exp));
  endtask

  initial begin
    rst               = 1'b1;
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i    = 1'b1;
    wbus.stall_i       = 1'b0;
    wbus.redirect_i    = 1'b0;
    wbus.redirect_pc_i = 32'h0;
    wbus.id_ready_i    = 1'b1;

    // 1: reset, then first fetch and first valid
    go(3);
    check("t1_rst_ce",    {63'b0, bus.rom_ce_o},   64'h0);
    check("t1_rst_addr",  {32'b0, bus.rom_addr_o}, 64'h0);
    check("t1_rst_valid", {63'b0, bus.id_valid_o}, 64'h0);
    check("t1_wrap_addr", {32'b0, wbus.rom_addr_o}, 64'hFFFF_FFF8);
    rst = 1'b0;
    go(1);
    check("t1_ce",        {63'b0, bus.rom_ce_o},   64'h1);
    check("t1_addr",      {32'b0, bus.rom_addr_o}, 64'h0);
    check("t1_valid",     {63'b0, bus.id_valid_o}, 64'h0);
    check("t1_wrap_ce",   {63'b0, wbus.rom_ce_o},  64'h1);

    // 2: streaming with ready held high; 5: wrap instance alongside
    for (int i = 0; i < 5; i++) begin
      go(1);
      lit_pc("t2_stream", 32'(i * 8));
      if (i == 0) check("t5_wrap_pc0", {32'b0, wbus.id_pc_o}, 64'hFFFF_FFF8);
      if (i == 1) check("t5_wrap_pc1", {32'b0, wbus.id_pc_o}, 64'h0);
      if (i == 1) check("t5_wrap_inst", wbus.id_inst_o, 64'h5A5A_C3C3_0000_0000);
    end

    // stall while streaming: PC frozen, FIFO drains
    bus.stall_i = 1'b1;
    go(3);
    check("stall_valid", {63'b0, bus.id_valid_o}, 64'h0);
    check("stall_ce",    {63'b0, bus.rom_ce_o},   64'h0);
    bus.stall_i = 1'b0;
    go(2);

    // 3: backpressure from reset
    bus.id_ready_i = 1'b0;
    rst = 1'b1;
    go(2);
    rst = 1'b0;
    go(1);
    check("t3_ce0", {63'b0, bus.rom_ce_o}, 64'h1);
    go(1);
    lit_pc("t3_head", 32'h0);
    go(1);
    check("t3_full_ce",   {63'b0, bus.rom_ce_o},   64'h0);
    check("t3_full_addr", {32'b0, bus.rom_addr_o}, 64'h10);
    lit_pc("t3_full", 32'h0);
    go(1);
    check("t3_stuck_addr", {32'b0, bus.rom_addr_o}, 64'h10);
    bus.id_ready_i = 1'b1;
    #1;
    check("t3_pop_ce", {63'b0, bus.rom_ce_o}, 64'h1);
    lit_pc("t3_d0", 32'h0);
    go(1);
    lit_pc("t3_d1", 32'h8);
    go(1);
    lit_pc("t3_d2", 32'h10);
    go(1);
    lit_pc("t3_d3", 32'h18);

    // 4: redirect to an unaligned target while full and stalled
    bus.id_ready_i = 1'b0;
    go(3);
    check("t4_full_ce", {63'b0, bus.rom_ce_o}, 64'h0);
    bus.stall_i       = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h103;
    go(1);
    bus.redirect_i = 1'b0;
    #1;
    check("t4_valid", {63'b0, bus.id_valid_o}, 64'h0);
    check("t4_addr",  {32'b0, bus.rom_addr_o}, 64'h100);
    check("t4_ce",    {63'b0, bus.rom_ce_o},   64'h0);
    bus.stall_i    = 1'b0;
    bus.id_ready_i = 1'b1;
    #1;
    check("t4_ce_go", {63'b0, bus.rom_ce_o}, 64'h1);
    go(1);
    lit_pc("t4_p0", 32'h100);
    go(1);
    lit_pc("t4_p1", 32'h108);

    // 6: asynchronous reset with two entries queued
    bus.id_ready_i = 1'b0;
    go(3);
    check("t6_pre_valid", {63'b0, bus.id_valid_o}, 64'h1);
    check("t6_pre_ce",    {63'b0, bus.rom_ce_o},   64'h0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ce",    {63'b0, bus.rom_ce_o},   64'h0);
    check("t6_addr",  {32'b0, bus.rom_addr_o}, 64'h0);
    check("t6_valid", {63'b0, bus.id_valid_o}, 64'h0);
    check("t6_pc",    {32'b0, bus.id_pc_o},    64'h0);
    check("t6_inst",  bus.id_inst_o,           64'h0);
    go(1);
    rst = 1'b0;
    bus.id_ready_i = 1'b1;
    go(1);
    check("t6_ce1",   {63'b0, bus.rom_ce_o},   64'h1);
    check("t6_addr1", {32'b0, bus.rom_addr_o}, 64'h0);
    go(1);
    lit_pc("t6_r0", 32'h0);
    go(1);
    lit_pc("t6_r1", 32'h8);
    go(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
